// File: rtl/i2c_arb_pkg.sv
// Shared types and widths for the i2c_master_arbiter slice.
// Contents: FSM state enum, I2C address/data widths, watchdog width,
// the latched command payload struct and an index-width helper.
package i2c_arb_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam int unsigned I2C_DATA_W = 8;
  localparam int unsigned WDOG_W     = 16;
  localparam int unsigned HOLD_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_START,
    ST_WAIT_LOW,
    ST_BUSY,
    ST_DONE
  } arb_state_e;

  // Command latched from the winning requester for one transaction.
  typedef struct packed {
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
    logic                  rw;
  } i2c_cmd_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Bundle of requester-side and i2c_master-side signals for the arbiter.
// Modports:
//   master : arbiter view (drives gnt/done/rdata/err and the m_* command)
//   slave  : environment view (requesters plus the i2c_master)
interface i2c_master_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import i2c_arb_pkg::*;

  logic [NUM_REQ-1:0]            req_i;
  logic [NUM_REQ*I2C_ADDR_W-1:0] addr_i;
  logic [NUM_REQ*I2C_DATA_W-1:0] wdata_i;
  logic [NUM_REQ-1:0]            rw_i;
  logic [NUM_REQ-1:0]            gnt_o;
  logic [NUM_REQ-1:0]            done_o;
  logic [I2C_DATA_W-1:0]         rdata_o;
  logic                          err_o;
  logic [I2C_ADDR_W-1:0]         m_addr;
  logic [I2C_DATA_W-1:0]         m_data_in;
  logic                          m_rw;
  logic                          m_enable;
  logic                          m_ready;
  logic [I2C_DATA_W-1:0]         m_data_out;

  modport master (
    input  req_i, addr_i, wdata_i, rw_i, m_ready, m_data_out,
    output gnt_o, done_o, rdata_o, err_o, m_addr, m_data_in, m_rw, m_enable
  );

  modport slave (
    output req_i, addr_i, wdata_i, rw_i, m_ready, m_data_out,
    input  gnt_o, done_o, rdata_o, err_o, m_addr, m_data_in, m_rw, m_enable
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit searching upward
// from ptr+1 (mod NUM_REQ). The pointer register lives in the parent.
// Ports: req (requests), ptr (last winner) -> gnt (one-hot), idx, any.
module rr_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]            req,
  input  logic [idx_width(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [idx_width(NUM_REQ)-1:0] idx,
  output logic                          any
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  logic        w_found;
  int unsigned w_pos;

  // Scan NUM_REQ positions starting just after the previous winner.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = |req;
    w_found = 1'b0;
    w_pos   = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_pos = (32'(ptr) + i) % NUM_REQ;
      if (!w_found && req[IDX_W'(w_pos)]) begin
        w_found           = 1'b1;
        gnt[IDX_W'(w_pos)] = 1'b1;
        idx               = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter/sequencer sharing one i2c_master between NUM_REQ
// requesters: picks a winner, latches its command onto the master, pulses
// the enable, follows i2c_ready through the transfer and returns done/rdata.
// Ports: clk, i2c_reset_n (async active-low), bus (i2c_master_arbiter_if.master).
// Optional build macro I2C_ARB_TIMEOUT_EN adds a watchdog that ends a stuck
// transfer after TIMEOUT_CYCLES with err_o; otherwise err_o is tied low.
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned EN_HOLD        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  i2c_reset_n,
  i2c_master_arbiter_if.master  bus
);

  localparam int unsigned IDX_W = idx_width(NUM_REQ);

  arb_state_e         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_win;
  logic [HOLD_W-1:0]  r_hold;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  i2c_cmd_t           w_cmd;
  logic               w_wdog_hit;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req (bus.req_i),
    .ptr (r_ptr),
    .gnt (w_gnt),
    .idx (w_idx),
    .any (w_any)
  );

  // Select the candidate winner's command fields.
  always_comb begin
    w_cmd = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_cmd.addr = bus.addr_i[k*I2C_ADDR_W +: I2C_ADDR_W];
        w_cmd.data = bus.wdata_i[k*I2C_DATA_W +: I2C_DATA_W];
        w_cmd.rw   = bus.rw_i[k];
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  logic [WDOG_W-1:0] r_wdog;

  // Zero outside the wait states, so it is clear on every WAIT_LOW entry.
  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      r_wdog <= '0;
    end else if (r_state == ST_WAIT_LOW || r_state == ST_BUSY) begin
      r_wdog <= r_wdog + WDOG_W'(1);
    end else begin
      r_wdog <= '0;
    end
  end

  assign w_wdog_hit = (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_wdog_hit = 1'b0;
  assign bus.err_o  = 1'b0;
`endif

  // Transaction sequencer; every output is a register of this block.
  always_ff @(posedge clk or negedge i2c_reset_n) begin
    if (!i2c_reset_n) begin
      r_state       <= ST_IDLE;
      r_ptr         <= IDX_W'(NUM_REQ - 1);
      r_win         <= '0;
      r_hold        <= '0;
      bus.gnt_o     <= '0;
      bus.done_o    <= '0;
      bus.rdata_o   <= '0;
      bus.m_addr    <= '0;
      bus.m_data_in <= '0;
      bus.m_rw      <= 1'b0;
      bus.m_enable  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      bus.err_o     <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if ((|bus.req_i) && bus.m_ready) r_state <= ST_ARB;
        end
        ST_ARB: begin
          if (w_any) begin
            r_win         <= w_idx;
            bus.gnt_o     <= w_gnt;
            bus.m_addr    <= w_cmd.addr;
            bus.m_data_in <= w_cmd.data;
            bus.m_rw      <= w_cmd.rw;
            r_state       <= ST_START;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        // Enable rises on the first START edge and stays up EN_HOLD cycles.
        ST_START: begin
          if (!bus.m_enable) begin
            bus.m_enable <= 1'b1;
            r_hold       <= HOLD_W'(1);
          end else if (r_hold == HOLD_W'(EN_HOLD)) begin
            bus.m_enable <= 1'b0;
            r_state      <= ST_WAIT_LOW;
          end else begin
            r_hold <= r_hold + HOLD_W'(1);
          end
        end
        ST_WAIT_LOW: begin
          if (w_wdog_hit) begin
            bus.done_o <= bus.gnt_o;
`ifdef I2C_ARB_TIMEOUT_EN
            bus.err_o  <= 1'b1;
`endif
            r_state    <= ST_DONE;
          end else if (!bus.m_ready) begin
            r_state <= ST_BUSY;
          end
        end
        // done_o is loaded here so it shows one edge after ready is seen high.
        ST_BUSY: begin
          if (bus.m_ready) begin
            bus.done_o <= bus.gnt_o;
            if (bus.m_rw) bus.rdata_o <= bus.m_data_out;
            r_state    <= ST_DONE;
          end else if (w_wdog_hit) begin
            bus.done_o <= bus.gnt_o;
`ifdef I2C_ARB_TIMEOUT_EN
            bus.err_o  <= 1'b1;
`endif
            r_state    <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.done_o <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
          bus.err_o  <= 1'b0;
`endif
          bus.gnt_o  <= '0;
          r_ptr      <= r_win;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
